mem_write_monitor: RTL and testbench

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

---
 rtl/mwm_pkg.sv | 15 +
 rtl/mwm_fifo.sv | 77 +++++++
 rtl/mem_write_monitor.sv | 116 +++++++++++
 tb/tb_mem_write_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mwm_pkg.sv
// Shared types for the memory write monitor: run-state enum and capture entry.
package mwm_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/mwm_fifo.sv
// Capture FIFO with a registered head (valid/addr/data) and valid/ready pop port.
module mwm_fifo
  import mwm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_entry,
  output logic                     drop,
  input  logic                     out_ready,
  output logic                     out_valid,
  output entry_t                   out_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               out_valid_r;
  entry_t             out_entry_r;
  logic               pop_s, accept_s, drop_s;
  entry_t             head_s;

  // Next pointers/occupancy and the entry that will sit at the head after this edge
  always_comb begin
    pop_s    = out_valid_r && out_ready;
    accept_s = push && ((count_r != CNT_W'(DEPTH)) || pop_s);
    drop_s   = push && !accept_s;
    rd_ptr_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    count_s  = count_r + CNT_W'(accept_s) - CNT_W'(pop_s);
    // An entry written into the slot that becomes the head must bypass the array
    if (accept_s && (wr_ptr_r == rd_ptr_s)) begin
      head_s = push_entry;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_entry_r <= '0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      out_valid_r <= (count_s != CNT_W'(0));
      if (count_s != CNT_W'(0)) begin
        out_entry_r <= head_s;
      end
    end
  end

  assign drop      = drop_s;
  assign out_valid = out_valid_r;
  assign out_entry = out_entry_r;
  assign count     = count_r;

endmodule

// File: rtl/mem_write_monitor.sv
// Watches CPU stores, queues them for a consumer and ends the run on a target store.
// Optional watchdog enabled by defining MWM_TIMEOUT_EN.
module mem_write_monitor
  import mwm_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] TARGET_ADDR = 32'h64,
  parameter logic [31:0] TARGET_DATA = 32'd7,
  parameter int          TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_write,
  input  logic [31:0]            data_adr,
  input  logic [31:0]            write_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout
);

  state_e state_r;
  logic   push_s, hit_s, drop_s, wd_expire_s;
  logic   overflow_r, done_r, pass_r, timeout_r;
  entry_t in_entry_s, head_s;

  // Capture qualification: only stores seen while the run is live
  always_comb begin
    push_s     = mem_write && (state_r == RUN);
    hit_s      = push_s && (data_adr == TARGET_ADDR);
    in_entry_s = '{addr: data_adr, data: write_data};
  end

`ifdef MWM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_r;

  // Watchdog: counts cycles spent in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r <= '0;
    end else if (state_r == RUN) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= wd_r;
    end
  end

  assign wd_expire_s = (state_r == RUN) && (wd_r == WD_W'(TIMEOUT - 1));
`else
  assign wd_expire_s = 1'b0;
`endif

  mwm_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (in_entry_s),
    .drop       (drop_s),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_entry  (head_s),
    .count      (count)
  );

  // Run FSM with registered status flags; a target store outranks the watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= RUN;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        RUN: begin
          if (hit_s) begin
            done_r <= 1'b1;
            if (write_data == TARGET_DATA) begin
              state_r <= PASS;
              pass_r  <= 1'b1;
            end else begin
              state_r <= FAIL;
            end
          end else if (wd_expire_s) begin
            state_r   <= FAIL;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
          end
        end
        PASS, FAIL: state_r <= state_r;
        default: begin
          state_r <= RUN;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_addr = head_s.addr;
  assign out_data = head_s.data;
  assign overflow = overflow_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_mem_write_monitor;

  localparam int          DEPTH   = 8;
  localparam int          TIMEOUT = 50;
  localparam logic [31:0] TGT_A   = 32'h64;
  localparam logic [31:0] TGT_D   = 32'd7;

  logic        clk = 1'b0;
  logic        reset, mem_write, out_ready;
  logic [31:0] data_adr, write_data, out_addr, out_data;
  logic        out_valid, overflow, done, pass, timeout;
  logic [3:0]  count;

  always #5 clk = ~clk;

  mem_write_monitor #(.DEPTH(DEPTH), .TARGET_ADDR(TGT_A), .TARGET_DATA(TGT_D),
                      .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .count(count), .overflow(overflow),
    .done(done), .pass(pass), .timeout(timeout)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of {addr,data}, run status (0 run, 1 pass, 2 fail)
  logic [63:0] q[$];
  int          m_state;
  bit          m_ovf, m_to;
  int          m_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_to    = 1'b0;
    m_cyc   = 0;
  endtask

  task automatic model_edge();
    bit pop, cap;
    pop = (q.size() != 0) && out_ready;
    cap = mem_write && (m_state == 0);
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEPTH) q.push_back({data_adr, write_data});
      else m_ovf = 1'b1;
    end
    if (m_state == 0) begin
      m_cyc++;
      if (cap && data_adr == TGT_A) m_state = (write_data == TGT_D) ? 1 : 2;
`ifdef MWM_TIMEOUT_EN
      else if (m_cyc == TIMEOUT) begin
        m_state = 2;
        m_to    = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, out_valid, q.size() != 0);
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".done"}, done, m_state != 0);
    chk({tag, ".pass"}, pass, m_state == 1);
    chk({tag, ".tmo"}, timeout, m_to);
    if (q.size() != 0) chk({tag, ".head"}, {out_addr, out_data}, q[0]);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_write = 1'b0; out_ready = 1'b0;
    data_adr = 32'd0; write_data = 32'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("rst");
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rdy,
                       input string tag);
    mem_write = 1'b1; data_adr = a; write_data = d; out_ready = rdy;
    cycle(tag);
    mem_write = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    out_ready = rdy;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    // Two ordinary stores drained back to back
    do_reset();
    store(32'h10, 32'hA, 1'b1, "s1");
    store(32'h14, 32'hB, 1'b1, "s2");
    idle(3, 1'b1, "drain2");
    chk("two_empty", count, 4'd0);

    // Matching target store, then a store that must be ignored
    do_reset();
    store(32'h64, 32'd7, 1'b0, "tgt_ok");
    chk("tgt_ok_pass", {done, pass}, 2'b11);
    store(32'h20, 32'd1, 1'b0, "post");
    chk("post_cnt", count, 4'd1);
    idle(3, 1'b1, "tgt_ok_drain");

    // Mismatching target store still drains
    do_reset();
    store(32'h64, 32'd5, 1'b0, "tgt_bad");
    chk("tgt_bad_flags", {done, pass}, 2'b10);
    chk("tgt_bad_head", {out_addr, out_data}, {32'h64, 32'd5});
    idle(2, 1'b1, "tgt_bad_drain");

    // Nine stores into a stalled FIFO, then drain
    do_reset();
    for (int i = 0; i < 9; i++) store(32'h100 + 32'(i * 4), 32'(i), 1'b0, "fill");
    chk("full_cnt", count, 4'd8);
    chk("full_ovf", overflow, 1'b1);
    idle(10, 1'b1, "ovf_drain");

    // Store with a simultaneous pop on a full FIFO
    do_reset();
    for (int i = 0; i < 8; i++) store(32'h200 + 32'(i * 4), 32'(i), 1'b0, "fill8");
    store(32'h300, 32'h55, 1'b1, "full_pp");
    chk("full_pp_cnt", count, 4'd8);
    chk("full_pp_ovf", overflow, 1'b0);
    idle(10, 1'b1, "pp_drain");

    // Watchdog behaviour
    do_reset();
    idle(TIMEOUT - 1, 1'b0, "wd");
    chk("wd_early", done, 1'b0);
    cycle("wd_edge");
`ifdef MWM_TIMEOUT_EN
    chk("wd_fire", {done, pass, timeout}, 3'b101);
`else
    idle(10, 1'b0, "wd_off");
    chk("wd_off", {done, timeout}, 2'b00);
`endif

    // Asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 4; i++) store(32'h40 + 32'(i * 4), 32'(i), 1'b0, "pre_rst");
    out_ready = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_cnt", count, 4'd0);
    chk("arst_head", {out_addr, out_data}, 64'd0);
    chk("arst_flags", {overflow, done, pass, timeout}, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2, 1'b1, "post_arst");

    // Randomized traffic in short runs
    for (int seg = 0; seg < 8; seg++) begin
      int rdy_pct;
      do_reset();
      rdy_pct = $urandom_range(10, 90);
      for (int c = 0; c < 40; c++) begin
        mem_write  = ($urandom_range(0, 99) < 60);
        data_adr   = 32'h40 + 32'($urandom_range(0, 15) * 4);
        write_data = 32'($urandom_range(5, 8));
        out_ready  = ($urandom_range(0, 99) < rdy_pct);
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
